// File: rtl/alu_pkg.sv
// Shared encodings for the execute sequencer: RV32 opcode/funct fields,
// ALU operation select, and sequencer state codes.
package alu_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_t;

  // State codes kept as plain constants so existing tools/scripts that
  // print raw state values keep working.
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE = 3'd0;
  localparam seq_state_t S_RS1  = 3'd1;
  localparam seq_state_t S_RS2  = 3'd2;
  localparam seq_state_t S_EXEC = 3'd3;
  localparam seq_state_t S_WB   = 3'd4;
  localparam seq_state_t S_ERR  = 3'd5;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational decode of one RV32 R-/I-type integer instruction into ALU
// op, register indices, operand-B immediate and an illegal flag.
module alu_instr_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [31:0]     instr,
  output alu_op_t         alu_op,
  output logic            is_rtype,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm_sext,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign is_rtype = (opcode == OPC_RTYPE);

  // Map opcode/funct fields to an ALU op; anything unrecognised is illegal.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    imm_sext = XLEN'(signed'(instr[31:20]));
    case (opcode)
      OPC_RTYPE: begin
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
          {F7_MUL,  F3_ADD}:  alu_op = ALU_MUL;
          {F7_BASE, F3_AND}:  alu_op = ALU_AND;
          {F7_BASE, F3_OR}:   alu_op = ALU_OR;
          {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
          {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
          {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
          {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
          default:            illegal = 1'b1;
        endcase
      end
      OPC_ITYPE: begin
        case (f3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_SLL: begin
            // Shift-immediates carry the shamt in imm[4:0]; imm[11:5] acts as f7.
            imm_sext = XLEN'(instr[24:20]);
            if (f7 == F7_BASE) alu_op = ALU_SLL;
            else               illegal = 1'b1;
          end
          F3_SR: begin
            imm_sext = XLEN'(instr[24:20]);
            if      (f7 == F7_BASE) alu_op = ALU_SRL;
            else if (f7 == F7_ALT)  alu_op = ALU_SRA;
            else                    illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller: accepts one instruction, reads rs1/rs2
// through a single synchronous RF port, drives the external ALU with operand
// values and writes the result back. One instruction in flight.
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter  int XLEN  = 16,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  seq_state_t      state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] result;

  logic [31:0]     dec_instr;
  alu_op_t         dec_op;
  logic            dec_is_rtype;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [XLEN-1:0] b_val;

  // In IDLE the live instruction is decoded so the accept edge can branch to
  // ERR; afterwards the latched copy drives every field.
  assign dec_instr = (state == S_IDLE) ? instr : instr_q;

  alu_instr_decode #(.XLEN(XLEN)) u_decode (
    .instr    (dec_instr),
    .alu_op   (dec_op),
    .is_rtype (dec_is_rtype),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm_sext (dec_imm),
    .illegal  (dec_illegal)
  );

  // rs2 data arrives in EXEC, the same cycle the ALU consumes it, so operand B
  // is taken live from the RF port (or the immediate) rather than registered.
  assign b_val = dec_is_rtype ? rf_rdata : dec_imm;

  // FSM and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      instr_q <= '0;
      op_a    <= '0;
      result  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= dec_illegal ? S_ERR : S_RS1;
          end
        end
        S_RS1:  state <= S_RS2;
        S_RS2: begin
          op_a  <= rf_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_result;
          state  <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // State-decoded outputs; everything idles at zero outside its own state.
  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    rf_raddr    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_RS1: rf_raddr = AW'(dec_rs1);
      S_RS2: rf_raddr = dec_is_rtype ? AW'(dec_rs2) : '0;
      S_EXEC: begin
        alu_a  = op_a;
        alu_b  = b_val;
        alu_op = dec_op;
      end
      S_WB: begin
        done     = 1'b1;
        rf_we    = (dec_rd != 5'd0);
        rf_waddr = AW'(dec_rd);
        rf_wdata = result;
      end
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with an RF/ALU model and a scoreboard
// of predicted retirements.
module tb_alu_exec_sequencer;
  import alu_pkg::*;

  localparam int XLEN = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_op;
  logic            busy, done, illegal;

  always #5 clk = ~clk;

  alu_exec_sequencer #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .busy(busy), .done(done), .illegal(illegal)
  );

  typedef struct {
    int              lat;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            ill;
    logic [4:0]      ra1, ra2;
    logic [XLEN-1:0] a, b;
    logic [3:0]      op;
  } exp_t;

  logic [XLEN-1:0] rf_mem [32];
  logic [XLEN-1:0] golden [32];
  exp_t            sb [$];
  int              total = 0, passed = 0, failed = 0;
  int              accept_cnt = 0, we_cnt = 0;

  function automatic logic [XLEN-1:0] alu_ref(logic [3:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    int sh;
    sh = int'(b % XLEN);
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_MUL:  r = XLEN'(a * b);
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU: r = (a < b) ? 1 : 0;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $signed(a) >>> sh;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // External RF (sync read, write at edge) and combinational ALU.
  always @(posedge clk) begin
    rf_rdata <= rf_mem[rf_raddr];
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
  end
  always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (instr_valid && instr_ready) accept_cnt <= accept_cnt + 1;
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Reference model: independent decode plus golden register file.
  function automatic exp_t predict(logic [31:0] ins);
    exp_t e;
    logic [6:0] opc = ins[6:0], f7 = ins[31:25];
    logic [2:0] f3 = ins[14:12];
    logic rtype = (opc == 7'h33), legal = 1'b1, shift = 1'b0;
    logic [3:0] op = ALU_ADD;
    if (rtype) begin
      case ({f7, f3})
        {7'h00, 3'd0}: op = ALU_ADD;   {7'h20, 3'd0}: op = ALU_SUB;
        {7'h01, 3'd0}: op = ALU_MUL;   {7'h00, 3'd7}: op = ALU_AND;
        {7'h00, 3'd6}: op = ALU_OR;    {7'h00, 3'd4}: op = ALU_XOR;
        {7'h00, 3'd2}: op = ALU_SLT;   {7'h00, 3'd3}: op = ALU_SLTU;
        {7'h00, 3'd1}: op = ALU_SLL;   {7'h00, 3'd5}: op = ALU_SRL;
        {7'h20, 3'd5}: op = ALU_SRA;
        default: legal = 1'b0;
      endcase
    end else if (opc == 7'h13) begin
      case (f3)
        3'd0: op = ALU_ADD;  3'd7: op = ALU_AND;  3'd6: op = ALU_OR;
        3'd4: op = ALU_XOR;  3'd2: op = ALU_SLT;  3'd3: op = ALU_SLTU;
        3'd1: begin shift = 1'b1; if (f7 == 7'h00) op = ALU_SLL; else legal = 1'b0; end
        default: begin
          shift = 1'b1;
          if (f7 == 7'h00) op = ALU_SRL; else if (f7 == 7'h20) op = ALU_SRA; else legal = 1'b0;
        end
      endcase
    end else legal = 1'b0;
    e.ra1   = ins[19:15];
    e.ra2   = rtype ? ins[24:20] : 5'd0;
    e.a     = golden[ins[19:15]];
    e.b     = rtype ? golden[ins[24:20]] :
              shift ? {11'd0, ins[24:20]} : {{(XLEN-12){ins[31]}}, ins[31:20]};
    e.op    = op;
    e.ill   = !legal;
    e.lat   = legal ? 4 : 1;
    e.we    = legal && (ins[11:7] != 5'd0);
    e.waddr = legal ? ins[11:7] : 5'd0;
    e.wdata = legal ? alu_ref(op, e.a, e.b) : '0;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction at a negedge; returns at the negedge after accept.
  task automatic send(logic [31:0] ins, bit hold);
    check("ready_before_send", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    sb.push_back(predict(ins));
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      instr_valid = 1'b0;
      instr = $urandom;
    end
  endtask

  // Follow the instruction to retirement and compare with the scoreboard head.
  task automatic retire(string tag);
    exp_t e;
    int lat = 1;
    logic [4:0] ra1 = '0, ra2 = '0;
    logic [XLEN-1:0] a = '0, b = '0;
    logic [3:0] op = '0;
    e = sb.pop_front();
    forever begin
      if (lat == 1) ra1 = rf_raddr;
      if (lat == 2) ra2 = rf_raddr;
      if (lat == 3) begin a = alu_a; b = alu_b; op = alu_op; end
      if (done || lat >= 10) break;
      check({tag, "_busy"}, busy, 1);
      @(negedge clk);
      lat++;
    end
    instr_valid = 1'b0;
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_rf_we"}, rf_we, e.we);
    check({tag, "_illegal"}, illegal, e.ill);
    check({tag, "_waddr"}, rf_waddr, e.waddr);
    check({tag, "_wdata"}, rf_wdata, e.wdata);
    if (!e.ill) begin
      check({tag, "_raddr_rs1"}, ra1, e.ra1);
      check({tag, "_raddr_rs2"}, ra2, e.ra2);
      check({tag, "_alu_a"}, a, e.a);
      check({tag, "_alu_b"}, b, e.b);
      check({tag, "_alu_op"}, op, e.op);
      check({tag, "_alu_idle_in_wb"}, {alu_op, alu_a}, '0);
    end
    if (e.we) golden[e.waddr] = e.wdata;
    @(negedge clk);
    check({tag, "_ready_after"}, instr_ready, 1);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; golden[i] = '0; end
    rf_mem[1] = 16'd5;     golden[1] = 16'd5;
    rf_mem[2] = 16'd7;     golden[2] = 16'd7;
    rf_mem[6] = 16'h8000;  golden[6] = 16'h8000;

    // Reset state, during and after reset.
    @(negedge clk);
    check("rst_outputs", {instr_ready, busy, rf_we, done, illegal}, 5'b10000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {instr_ready, busy, rf_we, done, illegal}, 5'b10000);

    send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0);  retire("add_x3");
    send(r_type(7'h20, 5'd1, 5'd1, 3'd0, 5'd1), 0);  retire("sub_x1_zero");
    send(i_type(12'hFFF, 5'd1, 3'd0, 5'd4), 0);      retire("addi_m1");
    send(i_type(12'h404, 5'd6, 3'd5, 5'd5), 0);      retire("srai_4");
    send(r_type(7'h20, 5'd1, 5'd2, 3'd0, 5'd0), 0);  retire("sub_rd0");
    send(r_type(7'h00, 5'd2, 5'd4, 3'd2, 5'd7), 0);  retire("slt_neg");
    send(r_type(7'h00, 5'd2, 5'd4, 3'd3, 5'd8), 0);  retire("sltu_big");
    send(r_type(7'h01, 5'd2, 5'd2, 3'd0, 5'd9), 0);  retire("mul");
    send(i_type(12'h0F0, 5'd2, 3'd4, 5'd10), 0);     retire("xori");
    send(i_type(12'hFFF, 5'd2, 3'd3, 5'd11), 0);     retire("sltiu_m1");
    send(i_type(12'h013, 5'd2, 3'd1, 5'd12), 0);     retire("slli_19");
    send({20'h00001, 5'd1, 7'b0110111}, 0);          retire("lui_illegal");
    send(r_type(7'h7F, 5'd2, 5'd1, 3'd0, 5'd3), 0);  retire("f7_illegal");

    // Reset asserted while the instruction is in EXEC: it must vanish.
    snap = we_cnt;
    send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd13), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_idle", {instr_ready, busy, done}, 3'b100);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_write", we_cnt, snap);
    send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd13), 0); retire("add_after_rst");

    // instr_valid held high while busy: only one acceptance.
    snap = accept_cnt;
    send(r_type(7'h00, 5'd1, 5'd2, 3'd0, 5'd14), 1); retire("add_held_valid");
    check("single_accept", accept_cnt - snap, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
